// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared player/game-state types for the board and the turn scheduler
package game_pkg;

    localparam int PLAYER_W = 3;

    typedef enum logic [PLAYER_W-1:0] {
        PL_NPC  = 3'd0,
        PL_RED  = 3'd1,
        PL_BLUE = 3'd2
    } player_t;

    typedef enum logic [1:0] {
        GS_IDLE   = 2'd0,
        GS_TURN   = 2'd1,
        GS_SWITCH = 2'd2,
        GS_OVER   = 2'd3
    } game_state_t;

    function automatic player_t next_player(input player_t p);
        return (p == PL_RED) ? PL_BLUE : PL_RED;
    endfunction

endpackage

// File: rtl/game_tick_divider.sv
// rtl/game_tick_divider.sv - one-second prescaler with synchronous clear and 1-cycle tick
module game_tick_divider
#(
    parameter int CLK_PER_SEC = 50000000
)
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Tick is high during the last prescaler cycle so the consumer updates on the wrap edge.
    assign o_tick = !i_clear && (r_count == LAST);

endmodule

// File: rtl/game_turn_scheduler.sv
// rtl/game_turn_scheduler.sv - game flow FSM: turns, countdown, rounds, growth events, winner latch
module game_turn_scheduler
    import game_pkg::*;
#(
    parameter int LOG2_MAX_PLAYER_CNT = 3,
    parameter int LOG2_MAX_ROUND      = 12,
    parameter int CLK_PER_SEC         = 50000000,
    parameter int TURN_SECONDS        = 10,
    parameter int GROWTH_PERIOD       = 25
)
(
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic                           i_move_done,
    input  logic                           i_win_valid,
    input  logic [LOG2_MAX_PLAYER_CNT-1:0] i_win_player,
    output logic [1:0]                     o_game_state,
    output logic                           o_ops_enable,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] o_current_player,
    output logic [LOG2_MAX_ROUND:0]        o_round,
    output logic [7:0]                     o_seconds_left,
    output logic                           o_turn_end,
    output logic                           o_timeout,
    output logic                           o_round_pulse,
    output logic                           o_growth_pulse,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] o_winner
);

    localparam int RW = LOG2_MAX_ROUND + 1;
    localparam int GW = $clog2(GROWTH_PERIOD + 1);
    localparam logic [GW-1:0] GROW_INIT = GW'((GROWTH_PERIOD == 1) ? 0 : 1);
    localparam logic [GW-1:0] GROW_LAST = GW'(GROWTH_PERIOD - 1);
    localparam logic [7:0]    SEC_LOAD  = 8'(TURN_SECONDS);
    localparam logic [RW-1:0] ROUND_MAX = '1;

    game_state_t   r_state;
    player_t       r_player;
    player_t       r_winner;
    logic          r_ops_en;
    logic [RW-1:0] r_round;
    logic [7:0]    r_secs;
    logic [GW-1:0] r_grow_cnt;
    logic          r_turn_end;
    logic          r_timeout;
    logic          r_round_pulse;
    logic          r_growth_pulse;

    logic          w_tick;
    logic          w_clear;
    logic [GW-1:0] w_grow_next;

    assign w_clear     = (r_state != GS_TURN);
    // r_grow_cnt tracks round % GROWTH_PERIOD without a divider.
    assign w_grow_next = (r_grow_cnt == GROW_LAST) ? '0 : r_grow_cnt + 1'b1;

    game_tick_divider #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= GS_IDLE;
            r_player       <= PL_RED;
            r_winner       <= PL_NPC;
            r_ops_en       <= 1'b0;
            r_round        <= RW'(1);
            r_secs         <= SEC_LOAD;
            r_grow_cnt     <= GROW_INIT;
            r_turn_end     <= 1'b0;
            r_timeout      <= 1'b0;
            r_round_pulse  <= 1'b0;
            r_growth_pulse <= 1'b0;
        end else begin
            r_turn_end     <= 1'b0;
            r_timeout      <= 1'b0;
            r_round_pulse  <= 1'b0;
            r_growth_pulse <= 1'b0;
            case (r_state)
                GS_IDLE, GS_OVER: begin
                    if (i_start) begin
                        r_state    <= GS_TURN;
                        r_ops_en   <= 1'b1;
                        r_player   <= PL_RED;
                        r_winner   <= PL_NPC;
                        r_round    <= RW'(1);
                        r_secs     <= SEC_LOAD;
                        r_grow_cnt <= GROW_INIT;
                    end
                end
                GS_TURN: begin
                    if (i_win_valid) begin
                        r_state  <= GS_OVER;
                        r_ops_en <= 1'b0;
                        r_winner <= player_t'(i_win_player);
                    end else if (i_move_done) begin
                        r_state    <= GS_SWITCH;
                        r_ops_en   <= 1'b0;
                        r_turn_end <= 1'b1;
                    end else if (w_tick) begin
                        r_secs <= r_secs - 1'b1;
                        if (r_secs == 8'd1) begin
                            r_state    <= GS_SWITCH;
                            r_ops_en   <= 1'b0;
                            r_turn_end <= 1'b1;
                            r_timeout  <= 1'b1;
                        end
                    end
                end
                GS_SWITCH: begin
                    if (i_win_valid) begin
                        r_state  <= GS_OVER;
                        r_winner <= player_t'(i_win_player);
                    end else if (r_player == PL_BLUE && r_round == ROUND_MAX) begin
                        r_state  <= GS_OVER;
                        r_winner <= PL_NPC;
                    end else begin
                        r_state  <= GS_TURN;
                        r_ops_en <= 1'b1;
                        r_player <= next_player(r_player);
                        r_secs   <= SEC_LOAD;
                        if (r_player == PL_BLUE) begin
                            r_round        <= r_round + 1'b1;
                            r_round_pulse  <= 1'b1;
                            r_grow_cnt     <= w_grow_next;
                            r_growth_pulse <= (w_grow_next == '0);
                        end
                    end
                end
                default: r_state <= GS_IDLE;
            endcase
        end
    end

    assign o_game_state     = r_state;
    assign o_ops_enable     = r_ops_en;
    assign o_current_player = r_player;
    assign o_round          = r_round;
    assign o_seconds_left   = r_secs;
    assign o_turn_end       = r_turn_end;
    assign o_timeout        = r_timeout;
    assign o_round_pulse    = r_round_pulse;
    assign o_growth_pulse   = r_growth_pulse;
    assign o_winner         = r_winner;

endmodule

// File: tb/tb_game_turn_scheduler.sv
// tb/tb_game_turn_scheduler.sv - self-checking bench for game_turn_scheduler against a behavioural model
module tb_game_turn_scheduler;

    localparam int C = 4;
    localparam int T = 3;
    localparam int G = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       move;
    logic       win;
    logic [2:0] wp;

    logic [1:0]  a_state, b_state;
    logic        a_ops, b_ops;
    logic [2:0]  a_pl, b_pl;
    logic [12:0] a_round;
    logic [1:0]  b_round;
    logic [7:0]  a_secs, b_secs;
    logic        a_te, b_te, a_to, b_to, a_rp, b_rp, a_gp, b_gp;
    logic [2:0]  a_win, b_win;

    game_turn_scheduler #(.LOG2_MAX_PLAYER_CNT(3), .LOG2_MAX_ROUND(12), .CLK_PER_SEC(C),
                          .TURN_SECONDS(T), .GROWTH_PERIOD(G)) dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_move_done(move),
        .i_win_valid(win), .i_win_player(wp), .o_game_state(a_state), .o_ops_enable(a_ops),
        .o_current_player(a_pl), .o_round(a_round), .o_seconds_left(a_secs),
        .o_turn_end(a_te), .o_timeout(a_to), .o_round_pulse(a_rp),
        .o_growth_pulse(a_gp), .o_winner(a_win)
    );

    game_turn_scheduler #(.LOG2_MAX_PLAYER_CNT(3), .LOG2_MAX_ROUND(1), .CLK_PER_SEC(C),
                          .TURN_SECONDS(T), .GROWTH_PERIOD(G)) dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_move_done(move),
        .i_win_valid(win), .i_win_player(wp), .o_game_state(b_state), .o_ops_enable(b_ops),
        .o_current_player(b_pl), .o_round(b_round), .o_seconds_left(b_secs),
        .o_turn_end(b_te), .o_timeout(b_to), .o_round_pulse(b_rp),
        .o_growth_pulse(b_gp), .o_winner(b_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase 0 idle, 1 turn, 2 switch, 3 over; players 0 npc, 1 red, 2 blue.
    int m_phase[2], m_player[2], m_round[2], m_secs[2], m_pre[2], m_winner[2];
    int m_te[2], m_to[2], m_rp[2], m_gp[2];
    int rmax[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_player[k] = 1; m_round[k] = 1; m_secs[k] = T;
            m_pre[k] = 0; m_winner[k] = 0;
            m_te[k] = 0; m_to[k] = 0; m_rp[k] = 0; m_gp[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_te[k] = 0; m_to[k] = 0; m_rp[k] = 0; m_gp[k] = 0;
            case (m_phase[k])
                0, 3: if (start) begin
                    m_phase[k] = 1; m_player[k] = 1; m_round[k] = 1;
                    m_secs[k] = T; m_pre[k] = 0; m_winner[k] = 0;
                end
                1: begin
                    if (win) begin
                        m_phase[k] = 3; m_winner[k] = int'(wp); m_pre[k] = 0;
                    end else if (move) begin
                        m_phase[k] = 2; m_te[k] = 1; m_pre[k] = 0;
                    end else if (m_pre[k] == C - 1) begin
                        m_pre[k] = 0;
                        m_secs[k] = m_secs[k] - 1;
                        if (m_secs[k] == 0) begin
                            m_phase[k] = 2; m_te[k] = 1; m_to[k] = 1;
                        end
                    end else begin
                        m_pre[k] = m_pre[k] + 1;
                    end
                end
                default: begin
                    m_pre[k] = 0;
                    if (win) begin
                        m_phase[k] = 3; m_winner[k] = int'(wp);
                    end else if (m_player[k] == 2 && m_round[k] == rmax[k]) begin
                        m_phase[k] = 3; m_winner[k] = 0;
                    end else begin
                        m_phase[k] = 1; m_secs[k] = T;
                        if (m_player[k] == 2) begin
                            m_player[k] = 1;
                            m_round[k] = m_round[k] + 1;
                            m_rp[k] = 1;
                            m_gp[k] = (m_round[k] % G == 0) ? 1 : 0;
                        end else begin
                            m_player[k] = 2;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic cmp_inst(input int k, input logic [1:0] st, input logic ops,
                            input logic [2:0] pl, input logic [12:0] rnd, input logic [7:0] secs,
                            input logic te, input logic to, input logic rp, input logic gp,
                            input logic [2:0] wn);
        check($sformatf("i%0d state", k), 32'(st), m_phase[k]);
        check($sformatf("i%0d ops_enable", k), 32'(ops), (m_phase[k] == 1) ? 1 : 0);
        check($sformatf("i%0d player", k), 32'(pl), m_player[k]);
        check($sformatf("i%0d round", k), 32'(rnd), m_round[k]);
        check($sformatf("i%0d seconds", k), 32'(secs), m_secs[k]);
        check($sformatf("i%0d turn_end", k), 32'(te), m_te[k]);
        check($sformatf("i%0d timeout", k), 32'(to), m_to[k]);
        check($sformatf("i%0d round_pulse", k), 32'(rp), m_rp[k]);
        check($sformatf("i%0d growth_pulse", k), 32'(gp), m_gp[k]);
        check($sformatf("i%0d winner", k), 32'(wn), m_winner[k]);
    endtask

    task automatic compare_all();
        cmp_inst(0, a_state, a_ops, a_pl, a_round, a_secs, a_te, a_to, a_rp, a_gp, a_win);
        cmp_inst(1, b_state, b_ops, b_pl, 13'(b_round), b_secs, b_te, b_to, b_rp, b_gp, b_win);
    endtask

    task automatic cycle(input logic s, input logic mv, input logic w, input logic [2:0] p);
        @(negedge clk);
        start = s; move = mv; win = w; wp = p;
        @(posedge clk);
        model_step();
        #1 compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; move = 1'b0; win = 1'b0; wp = 3'd0;
        rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic scenario_first_move();
        cycle(1'b1, 1'b0, 1'b0, 3'd0);
        check("t1 turn after start", 32'(a_state), 1);
        idle(4);
        cycle(1'b0, 1'b1, 1'b0, 3'd0);
        check("t1 switch state", 32'(a_state), 2);
        check("t1 switch turn_end", 32'(a_te), 1);
        idle(1);
        check("t1 blue state", 32'(a_state), 1);
        check("t1 blue player", 32'(a_pl), 2);
        check("t1 blue seconds", 32'(a_secs), 3);
        check("t1 blue round", 32'(a_round), 1);
    endtask

    int mrate;

    initial begin
        rstn_init: begin
            rst_n = 1'b1; start = 1'b0; move = 1'b0; win = 1'b0; wp = 3'd0;
        end
        rmax[0] = 8191;
        rmax[1] = 3;
        model_reset();

        do_reset();
        check("reset state", 32'(a_state), 0);
        check("reset player", 32'(a_pl), 1);

        scenario_first_move();

        idle(11);
        check("t2 secs before expiry", 32'(a_secs), 1);
        idle(1);
        check("t2 timeout", 32'(a_to), 1);
        check("t2 secs zero", 32'(a_secs), 0);
        idle(1);
        check("t2 round 2", 32'(a_round), 2);
        check("t2 round_pulse", 32'(a_rp), 1);
        check("t2 growth_pulse", 32'(a_gp), 1);
        check("t2 red again", 32'(a_pl), 1);

        idle(11);
        cycle(1'b0, 1'b1, 1'b0, 3'd0);
        check("t3 turn_end", 32'(a_te), 1);
        check("t3 no timeout", 32'(a_to), 0);
        idle(1);
        check("t3 single switch", 32'(a_state), 1);

        cycle(1'b0, 1'b1, 1'b1, 3'd2);
        check("t4 over", 32'(a_state), 3);
        check("t4 winner", 32'(a_win), 2);
        check("t4 ops off", 32'(a_ops), 0);
        check("t4 no turn_end", 32'(a_te), 0);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 3'd0);
        check("t4 restart state", 32'(a_state), 1);
        check("t4 restart round", 32'(a_round), 1);
        check("t4 restart winner", 32'(a_win), 0);

        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 3'd0);
            idle(1);
        end
        check("t5 saturated over", 32'(b_state), 3);
        check("t5 winner npc", 32'(b_win), 0);
        check("t5 no round_pulse", 32'(b_rp), 0);
        check("t5 wide instance round 4", 32'(a_round), 4);

        cycle(1'b0, 1'b1, 1'b0, 3'd0);
        check("t6 in switch", 32'(a_state), 2);
        do_reset();
        check("t6 reset state", 32'(a_state), 0);
        check("t6 reset turn_end", 32'(a_te), 0);
        scenario_first_move();

        mrate = 10;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: mrate = 2;
                    1: mrate = 10;
                    default: mrate = 35;
                endcase
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 99) < mrate),
                      ($urandom_range(0, 59) == 0), 3'($urandom_range(0, 2)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
